vram_arb: RTL and testbench
===========================

# vram_arb

Arbiter and sequencer for the single-port VRAM (32768 × 12, 15-bit address) that feeds the display pipeline. It gives the display read path exclusive use of the port while `hen & ven` is high. Blanking cycles are shared between two write requesters and a built-in screen-clear engine. It sits between the scan-timing and display-data blocks and the VRAM port A, and replaces the hard-wired `wea = 0` connection.

## Interface
- `AW`, 15, VRAM address width
- `DW`, 12, VRAM data width (4:4:4 RGB)
- `DEPTH`, 30000, number of valid pixel words (200 × 150); addresses ≥ DEPTH are invalid
- `pclk` in 1 — pixel clock, sole clock
- `rstn` in 1 — reset, asynchronous, active-low
- `hen`, `ven` in 1 each — active-video enables from the scan-timing block
- `disp_raddr` in AW — display read address from the display-data block
- `wreq0`, `wreq1` in 1 each — write requests; each held with its addr/data until its ack
- `waddr0`, `waddr1` in AW; `wdata0`, `wdata1` in DW — write address/data per requester
- `wack0`, `wack1` out 1 each — one-cycle acknowledge; the write is on the port this cycle
- `clr_start` in 1 — one-cycle pulse that starts a full-screen fill
- `clr_color` in DW — fill colour, sampled on an accepted `clr_start`
- `clr_busy` out 1 — fill in progress
- `clr_done` out 1 — one-cycle pulse after the last fill write
- `wr_err` out 1 — sticky; set by an invalid-address request; cleared only by reset
- `vram_addr` out AW, `vram_we` out 1, `vram_din` out DW — registered VRAM port A drive

## Operation
- Cycle classification at cycle t: ACTIVE if `hen & ven`, else BLANK.
- ACTIVE: next `vram_addr = disp_raddr`, `vram_we = 0`. No write is granted and no ack is issued.
- BLANK priority, highest first:
  - clear engine while `clr_busy`
  - round-robin between eligible requesters
  - idle: `vram_we = 0`, `vram_addr` holds `disp_raddr`
- Eligible requester: `wreq` is high and it was not granted in cycle t-1. This prevents a double write while its ack is visible.
- Round-robin: a 1-bit pointer names the preferred requester and flips to the other after each requester grant. The reset value prefers requester 0. If only one requester is eligible, it wins regardless of the pointer. The clear engine never moves the pointer.
- Invalid address (waddr ≥ DEPTH):
  - the request is granted and acked normally
  - `vram_we` stays 0 for that slot
  - `wr_err` is set
- FSM states:
  - IDLE: `clr_start` → CLEAR. Latches `clr_color` and sets counter = 0.
  - CLEAR: each BLANK cycle writes `clr_color` at counter and increments it. The write at counter = DEPTH-1 → IDLE with `clr_done`.
- `clr_start` while in CLEAR is ignored. No restart, no colour change.
- `clr_start` in the same cycle as a pending request: the clear takes that BLANK cycle, and the request waits.
- Counter width is AW. It never wraps, because it stops at DEPTH-1.
- Reset mid-fill aborts the fill. No `clr_done` is issued and VRAM contents are undefined.

## Timing
- All outputs are registered. Values for the decision made in cycle t appear at t+1.
- Display read address: latency of 1 cycle from `disp_raddr` to `vram_addr`. The display-data block accounts for this extra cycle.
- Grant at t → at t+1:
  - `vram_we = 1` (0 if invalid)
  - `vram_addr`/`vram_din` = the sampled addr/data
  - the matching `wack` = 1 for exactly one cycle
- A requester may drop or change `wreq`/addr/data at t+1.
- The earliest re-grant of the same requester is t+2.
- Throughput:
  - one write per BLANK cycle in total
  - two saturating requesters alternate grants every cycle
- Clear duration: exactly DEPTH BLANK cycles after `clr_start`.
  - `clr_busy` rises at t+1 after an accepted `clr_start`.
  - `clr_busy` falls at the cycle after the final write, together with the one-cycle `clr_done`.
- Reset values: `vram_addr = 0`, `vram_we = 0`, `vram_din = 0`, `wack0/1 = 0`, `clr_busy = 0`, `clr_done = 0`, `wr_err = 0`. FSM = IDLE, RR pointer = 0, counter = 0.

## Test plan
- Display passthrough: `hen = ven = 1`, `disp_raddr` sweeps 0..199, `wreq0` held high → `vram_addr` follows with 1-cycle lag, `vram_we` = 0 throughout, and `wack0` = 0 until blanking.
- Single write in blank: `hen = 0`, `wreq0 = 1`, `waddr0 = 0x0123`, `wdata0 = 0xF0A` → next cycle `vram_we = 1`, `vram_addr = 0x0123`, `vram_din = 0xF0A`, `wack0 = 1`. Holding `wreq0` produces the next ack two cycles later, not one.
- Fairness: both requests held for 8 BLANK cycles → acks alternate 0,1,0,1…; 8 writes total, 4 each, and no cycle has both acks.
- Clear: `clr_start` with `clr_color = 0x00F` and a blanking-only stimulus → exactly 30000 writes at addresses 0..29999, `clr_done` pulses once, and a `clr_start` issued mid-fill changes nothing. With a 50% ACTIVE duty, the completion time doubles.
- Invalid address: `waddr1 = 30000` in blank → `wack1 = 1`, `vram_we = 0`, and `wr_err` goes high and stays high. A following valid write still proceeds.
- Reset mid-fill: `rstn` low at count 1000 → all outputs return to their reset values asynchronously, and there is no `clr_done`. After release, `clr_busy = 0`.

Source files
------------

// File: rtl/vram_arb_if.sv
// vram_arb_if: display, write-requester, clear-engine and VRAM port A signals of the arbiter.
interface vram_arb_if #(parameter int AW = 15, parameter int DW = 12);
  logic          hen;
  logic          ven;
  logic [AW-1:0] disp_raddr;
  logic          wreq0;
  logic          wreq1;
  logic [AW-1:0] waddr0;
  logic [AW-1:0] waddr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          wack0;
  logic          wack1;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic          wr_err;
  logic [AW-1:0] vram_addr;
  logic          vram_we;
  logic [DW-1:0] vram_din;
  modport slave (
    input  hen, ven, disp_raddr, wreq0, wreq1, waddr0, waddr1, wdata0, wdata1, clr_start, clr_color,
    output wack0, wack1, clr_busy, clr_done, wr_err, vram_addr, vram_we, vram_din
  );
  modport master (
    output hen, ven, disp_raddr, wreq0, wreq1, waddr0, waddr1, wdata0, wdata1, clr_start, clr_color,
    input  wack0, wack1, clr_busy, clr_done, wr_err, vram_addr, vram_we, vram_din
  );
endinterface

// File: rtl/vram_arb.sv
// vram_arb: VRAM port A arbiter; display reads own active video, blanking is shared
// between the screen-clear engine and two round-robin write requesters.
module vram_arb #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int DEPTH = 30000
) (
  input logic       pclk,
  input logic       rstn,
  vram_arb_if.slave bus
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t        r_state, w_state;
  logic [AW-1:0] r_cnt, w_cnt, r_addr, w_addr;
  logic [DW-1:0] r_color, w_color, r_din, w_din;
  logic          r_ptr, w_ptr, r_we, w_we, r_ack0, r_ack1, r_done, r_err, w_err;
  logic          w_active, w_cw, w_last, w_start, w_free, w_e0, w_e1, w_g0, w_g1, w_v0, w_v1;

  always_comb begin
    w_active = bus.hen & bus.ven;
    w_start  = (r_state == IDLE) & bus.clr_start;
    w_cw     = ~w_active & (r_state == CLEAR);
    w_last   = w_cw & (r_cnt == AW'(DEPTH - 1));
    // a requester acked last cycle still shows wreq high, so it must sit this one out
    w_e0     = bus.wreq0 & ~r_ack0;
    w_e1     = bus.wreq1 & ~r_ack1;
    w_free   = ~w_active & (r_state == IDLE) & ~bus.clr_start;
    w_g0     = w_free & w_e0 & (~w_e1 | ~r_ptr);
    w_g1     = w_free & w_e1 & (~w_e0 | r_ptr);
    w_v0     = bus.waddr0 < AW'(DEPTH);
    w_v1     = bus.waddr1 < AW'(DEPTH);
    w_addr   = w_cw ? r_cnt : w_g0 ? bus.waddr0 : w_g1 ? bus.waddr1 : bus.disp_raddr;
    w_din    = w_cw ? r_color : w_g0 ? bus.wdata0 : w_g1 ? bus.wdata1 : r_din;
    w_we     = w_cw | (w_g0 & w_v0) | (w_g1 & w_v1);
    w_err    = r_err | (w_g0 & ~w_v0) | (w_g1 & ~w_v1);
    w_ptr    = (w_g0 | w_g1) ? w_g0 : r_ptr;
    w_state  = w_start ? CLEAR : w_last ? IDLE : r_state;
    w_cnt    = w_start ? '0 : (w_cw & ~w_last) ? r_cnt + 1'b1 : r_cnt;
    w_color  = w_start ? bus.clr_color : r_color;
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_color <= '0;
      r_ptr   <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_we    <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_color <= w_color;
      r_ptr   <= w_ptr;
      r_addr  <= w_addr;
      r_din   <= w_din;
      r_we    <= w_we;
      r_ack0  <= w_g0;
      r_ack1  <= w_g1;
      r_done  <= w_last;
      r_err   <= w_err;
    end
  end

  assign bus.vram_addr = r_addr;
  assign bus.vram_we   = r_we;
  assign bus.vram_din  = r_din;
  assign bus.wack0     = r_ack0;
  assign bus.wack1     = r_ack1;
  assign bus.clr_busy  = (r_state == CLEAR);
  assign bus.clr_done  = r_done;
  assign bus.wr_err    = r_err;
endmodule

// File: tb/tb_vram_arb.sv
// tb_vram_arb: randomized scoreboard bench; a cycle-level reference model predicts every
// registered output one cycle ahead and a negedge monitor compares them.
module tb_vram_arb;
  localparam int AW = 15, DW = 12, DEPTH = 30000;
  logic pclk = 1'b0;
  logic rstn = 1'b0;
  vram_arb_if #(.AW(AW), .DW(DW)) bus ();
  vram_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (.pclk(pclk), .rstn(rstn), .bus(bus));
  always #5 pclk = ~pclk;

  typedef struct {
    int            tag;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] din;
    logic          ack0, ack1, busy, done, err;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  int n_ack0 = 0, n_ack1 = 0, n_both = 0, n_we = 0, n_done = 0;
  bit m_busy = 0, m_err = 0;
  bit m_last[2] = '{0, 0};
  int m_cnt = 0, m_pref = 0;
  logic [DW-1:0] m_color = '0, m_din = '0;

  function automatic void check_eq(string name, longint got, longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic longint pack_dut();
    return longint'({bus.vram_addr, bus.vram_we, bus.vram_din, bus.wack0, bus.wack1,
                     bus.clr_busy, bus.clr_done, bus.wr_err});
  endfunction

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) if (rstn) begin
    exp_t e;
    while (q.size() > 0 && q[0].tag < cyc) begin
      e = q.pop_front();
      check_eq("missed_expectation", longint'(e.tag), longint'(cyc));
    end
    if (q.size() > 0 && q[0].tag == cyc) begin
      e = q.pop_front();
      check_eq("outputs", pack_dut(),
               longint'({e.addr, e.we, e.din, e.ack0, e.ack1, e.busy, e.done, e.err}));
    end
    n_ack0 += int'(bus.wack0);
    n_ack1 += int'(bus.wack1);
    n_both += int'(bus.wack0 & bus.wack1);
    n_we   += int'(bus.vram_we);
    n_done += int'(bus.clr_done);
  end

  // Reference model: one call per cycle, predicting the outputs of the next cycle.
  task automatic model_step();
    exp_t e;
    bit act, start, el0, el1;
    int w, a;
    act   = bus.hen && bus.ven;
    start = !m_busy && bus.clr_start;
    e.tag = cyc + 1; e.ack0 = 0; e.ack1 = 0; e.we = 0; e.done = 0;
    e.addr = bus.disp_raddr; e.din = m_din;
    if (!act && m_busy) begin
      e.addr = AW'(m_cnt); e.we = 1; e.din = m_color;
      m_cnt++;
      if (m_cnt == DEPTH) begin m_busy = 0; e.done = 1; end
    end else if (!act && !m_busy && !start) begin
      el0 = bus.wreq0 && !m_last[0];
      el1 = bus.wreq1 && !m_last[1];
      w = el0 && el1 ? m_pref : el0 ? 0 : el1 ? 1 : -1;
      if (w >= 0) begin
        a      = (w == 1) ? int'(bus.waddr1) : int'(bus.waddr0);
        e.addr = AW'(a);
        e.din  = (w == 1) ? bus.wdata1 : bus.wdata0;
        e.we   = a < DEPTH;
        if (a >= DEPTH) m_err = 1;
        if (w == 0) e.ack0 = 1; else e.ack1 = 1;
        m_pref = 1 - w;
      end
    end
    if (start) begin m_busy = 1; m_cnt = 0; m_color = bus.clr_color; end
    m_last[0] = e.ack0; m_last[1] = e.ack1; m_din = e.din;
    e.busy = m_busy; e.err = m_err;
    q.push_back(e);
  endtask

  task automatic tick(); @(posedge pclk); #1; endtask
  task automatic step(); model_step(); tick(); endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_last = '{0, 0}; m_cnt = 0; m_pref = 0; m_din = '0;
  endtask

  task automatic async_reset();
    #2 rstn = 1'b0;
    q.delete();
    model_reset();
    #1 check_eq("async_reset_outputs", pack_dut(), 0);
    tick();
    check_eq("reset_held_outputs", pack_dut(), 0);
    rstn = 1'b1;
  endtask

  initial begin
    int k, d0;
    bus.hen = 0; bus.ven = 0; bus.disp_raddr = '0;
    bus.wreq0 = 0; bus.wreq1 = 0; bus.waddr0 = '0; bus.waddr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0; bus.clr_start = 0; bus.clr_color = '0;
    tick(); tick();
    check_eq("reset_outputs", pack_dut(), 0);
    rstn = 1'b1;

    // display passthrough with a pending request that must wait for blanking
    bus.hen = 1; bus.ven = 1; bus.wreq0 = 1; bus.waddr0 = AW'(12'h055); bus.wdata0 = DW'(12'h123);
    n_ack0 = 0; n_we = 0;
    for (int i = 0; i < 200; i++) begin bus.disp_raddr = AW'(i); step(); end
    bus.hen = 0; bus.waddr0 = AW'(16'h0123); bus.wdata0 = DW'(12'hF0A);
    step();
    check_eq("active_no_ack", n_ack0, 0);
    check_eq("active_no_we", n_we, 0);
    check_eq("single_write", longint'({bus.vram_we, bus.vram_addr, bus.vram_din, bus.wack0}),
             longint'({1'b1, AW'(16'h0123), DW'(12'hF0A), 1'b1}));
    n_ack0 = 0;
    for (int i = 0; i < 5; i++) step();
    bus.wreq0 = 0; step();
    check_eq("held_req_acks_every_other", n_ack0, 3);

    // fairness with both requesters saturating
    n_ack0 = 0; n_ack1 = 0; n_both = 0; n_we = 0;
    bus.wreq0 = 1; bus.wreq1 = 1; bus.waddr0 = AW'(10); bus.waddr1 = AW'(20);
    bus.wdata0 = DW'(12'h0AA); bus.wdata1 = DW'(12'h0BB);
    for (int i = 0; i < 8; i++) step();
    bus.wreq0 = 0; bus.wreq1 = 0; step();
    check_eq("fair_ack0", n_ack0, 4);
    check_eq("fair_ack1", n_ack1, 4);
    check_eq("fair_no_double_ack", n_both, 0);
    check_eq("fair_writes", n_we, 8);

    // invalid address is acked without a write and sets the sticky error
    bus.wreq1 = 1; bus.waddr1 = AW'(DEPTH); bus.wdata1 = DW'(12'hABC);
    step();
    check_eq("invalid_ack_we_err", longint'({bus.wack1, bus.vram_we, bus.wr_err}), longint'(3'b101));
    bus.wreq1 = 0; bus.wreq0 = 1; bus.waddr0 = AW'(5); bus.wdata0 = DW'(12'h111);
    step();
    check_eq("valid_after_invalid", longint'({bus.wack0, bus.vram_we, bus.wr_err}), longint'(3'b111));
    bus.wreq0 = 0; step();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.hen = 1'($urandom % 2);
      bus.ven = ($urandom_range(0, 3) != 0);
      bus.disp_raddr = AW'($urandom % DEPTH);
      if (bus.wreq0 && bus.wack0) bus.wreq0 = 0;
      if (bus.wreq1 && bus.wack1) bus.wreq1 = 0;
      if (!bus.wreq0 && $urandom % 3 == 0) begin
        bus.wreq0 = 1; bus.wdata0 = DW'($urandom);
        bus.waddr0 = ($urandom % 8 == 0) ? AW'(DEPTH + $urandom % 2768) : AW'($urandom % DEPTH);
      end
      if (!bus.wreq1 && $urandom % 3 == 0) begin
        bus.wreq1 = 1; bus.wdata1 = DW'($urandom);
        bus.waddr1 = ($urandom % 8 == 0) ? AW'(DEPTH + $urandom % 2768) : AW'($urandom % DEPTH);
      end
      step();
    end
    bus.hen = 0; bus.ven = 0; bus.wreq0 = 0; bus.wreq1 = 0; step();

    // full clear in blanking, with a request waiting and a restart attempt mid-fill
    n_we = 0; n_done = 0;
    bus.clr_color = DW'(12'h00F); bus.clr_start = 1;
    bus.wreq0 = 1; bus.waddr0 = AW'(7); bus.wdata0 = DW'(12'h777);
    step();
    bus.clr_start = 0;
    for (k = 0; k < 31000 && n_done == 0; k++) begin
      bus.clr_start = (k == 100); bus.clr_color = (k == 100) ? DW'(12'hF00) : DW'(12'h00F);
      step();
    end
    bus.clr_start = 0;
    check_eq("clear_done_pulses", n_done, 1);
    check_eq("clear_write_count", n_we, DEPTH);
    check_eq("clear_busy_after", longint'(bus.clr_busy), 0);
    step(); step();
    bus.wreq0 = 0; step(); step();
    check_eq("clear_done_once", n_done, 1);

    // 50% active duty fill, aborted by reset at count 1000
    bus.clr_color = DW'(12'h0F0); bus.clr_start = 1; step();
    bus.clr_start = 0;
    for (k = 0; k < 5000 && m_cnt < 1000; k++) begin
      bus.hen = 1'(k % 2); bus.ven = 1'(k % 2); step();
    end
    bus.hen = 0; bus.ven = 0;
    check_eq("half_duty_cycles_to_1000", longint'(k >= 1998 && k <= 2002), 1);
    check_eq("half_duty_still_busy", longint'(bus.clr_busy), 1);
    d0 = n_done;
    async_reset();
    for (int i = 0; i < 4; i++) step();
    check_eq("busy_low_after_reset", longint'(bus.clr_busy), 0);
    check_eq("no_done_after_abort", n_done, d0);

    tick();
    check_eq("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
